// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit.
// Multiplies by shift-add and divides by restoring shift-subtract, one bit
// per cycle, working on operand magnitudes. The sign of the result is fixed
// up when the result is written. Division by zero and the signed overflow
// case skip the iteration and produce their result directly.
module muldiv_unit #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [size-1:0] A,
  input  logic [size-1:0] B,
  input  logic [2:0]      Sel,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [size-1:0] S,
  output logic            div_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int                CNT_W    = $clog2(size + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(size);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [size-1:0]   MIN_NEG  = {1'b1, {(size-1){1'b0}}};

  // Two's-complement negation when n is set (single width).
  function automatic logic [size-1:0] neg_if(input logic [size-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Two's-complement negation when n is set (double width product).
  function automatic logic [2*size-1:0] neg_if_wide(input logic [2*size-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op;
  logic             neg;
  logic [size-1:0]  hi;   // product high half / partial remainder
  logic [size-1:0]  lo;   // multiplier bits / dividend-then-quotient bits
  logic [size-1:0]  bm;   // multiplicand / divisor magnitude

  // Request decode
  logic            accept;
  logic            is_div;
  logic            a_signed, b_signed;
  logic            a_neg, b_neg;
  logic [size-1:0] a_mag, b_mag;
  logic            b_zero, sgn_ovf, special;
  logic [size-1:0] special_res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  assign is_div      = Sel[2];
  assign a_signed    = (Sel == 3'b001) || (Sel == 3'b010) || (Sel == 3'b100) || (Sel == 3'b110);
  assign b_signed    = (Sel == 3'b001) || (Sel == 3'b100) || (Sel == 3'b110);
  assign a_neg       = a_signed && A[size-1];
  assign b_neg       = b_signed && B[size-1];
  assign a_mag       = neg_if(A, a_neg);
  assign b_mag       = neg_if(B, b_neg);
  assign b_zero      = (B == '0);
  assign sgn_ovf     = is_div && !Sel[0] && (A == MIN_NEG) && (B == '1);
  assign special     = is_div && (b_zero || sgn_ovf);
  assign special_res = b_zero ? (Sel[1] ? A : '1) : (Sel[1] ? '0 : A);

  // One iteration step
  logic [size:0]     mul_sum;
  logic [size:0]     div_sh, div_trial;
  logic [size-1:0]   step_hi, step_lo;
  logic [2*size-1:0] prod_s;
  logic [size-1:0]   final_res;

  // Compute the next hi/lo pair for the operation in flight and its final result.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, bm} : '0);
    div_sh    = {hi, lo[size-1]};
    div_trial = div_sh - {1'b0, bm};
    if (op[2]) begin
      if (!div_trial[size]) begin
        step_hi = div_trial[size-1:0];
        step_lo = {lo[size-2:0], 1'b1};
      end else begin
        step_hi = div_sh[size-1:0];
        step_lo = {lo[size-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[size:1];
      step_lo = {mul_sum[0], lo[size-1:1]};
    end
    prod_s = neg_if_wide({step_hi, step_lo}, neg);
    if (op[2])
      final_res = op[1] ? neg_if(step_hi, neg) : neg_if(step_lo, neg);
    else if (op == 3'b000)
      final_res = prod_s[size-1:0];
    else
      final_res = prod_s[2*size-1:size];
  end

  // Sequence IDLE -> CALC -> DONE; flush returns to IDLE from anywhere.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= special ? DONE : CALC;
            cnt   <= special ? '0 : CNT_LOAD;
          end
        end
        CALC: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture operands on acceptance, iterate in CALC, write the result once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op       <= '0;
      neg      <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      bm       <= '0;
      S        <= '0;
      div_zero <= 1'b0;
    end else if (!flush) begin
      if (accept) begin
        op  <= Sel;
        neg <= (Sel[2] && Sel[1]) ? a_neg : (a_neg ^ b_neg);
        hi  <= '0;
        lo  <= is_div ? a_mag : b_mag;
        bm  <= is_div ? b_mag : a_mag;
        if (special) begin
          S        <= special_res;
          div_zero <= b_zero;
        end
      end else if (state == CALC) begin
        hi <= step_hi;
        lo <= step_lo;
        if (cnt == CNT_ONE) begin
          S        <= final_res;
          div_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit (size = 32): directed vectors plus random
// operations compared against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [2:0]   Sel = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] S;
  logic         div_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.size(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Sel(Sel), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .S(S), .div_zero(div_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: result, div_zero flag and latency from plain 64-bit arithmetic.
  function automatic void model(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic dz, output int lat);
    longint      sp;
    logic [63:0] up;
    logic [31:0] q;
    dz  = 1'b0;
    lat = W + 1;
    res = '0;
    case (sel)
      3'd0: begin up = {32'd0, a} * {32'd0, b}; res = up[31:0]; end
      3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); res = sp[63:32]; end
      3'd2: begin sp = longint'($signed(a)) * longint'({32'd0, b}); res = sp[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; res = up[63:32]; end
      3'd4, 3'd6: begin
        if (b == 32'd0) begin
          res = (sel == 3'd4) ? 32'hFFFF_FFFF : a; dz = 1'b1; lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          res = (sel == 3'd4) ? a : 32'd0; lat = 1;
        end else begin
          q = (sel == 3'd4) ? ($signed(a) / $signed(b)) : ($signed(a) % $signed(b));
          res = q;
        end
      end
      default: begin
        if (b == 32'd0) begin
          res = (sel == 3'd5) ? 32'hFFFF_FFFF : a; dz = 1'b1; lat = 1;
        end else begin
          res = (sel == 3'd5) ? (a / b) : (a % b);
        end
      end
    endcase
  endfunction

  // Issue one operation (called just after a rising edge with the unit idle),
  // check latency/result, stall for 'hold' cycles, then consume it.
  task automatic run_op(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string tag);
    logic [31:0] er;
    logic        edz;
    int          elat, lat, errs;
    model(sel, a, b, er, edz, elat);
    check({tag, "_in_ready"}, in_ready, 1);
    Sel = sel; A = a; B = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; A = $urandom; B = $urandom; Sel = 3'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_S"}, S, er);
    check({tag, "_dz"}, div_zero, edz);
    errs = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (S !== er || div_zero !== edz || out_valid !== 1'b1 || in_ready !== 1'b0) errs++;
    end
    if (hold > 0) check({tag, "_hold"}, errs, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_release"}, out_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rsel;
    logic [31:0] ra, rb, s_before;
    int          cnt;

    // Reset state while reset is held low
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_S", S, 0);
    check("rst_dz", div_zero, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, "mul");
    run_op(3'd1, 32'd7, 32'hFFFF_FFFD, 0, "mulh");
    run_op(3'd3, 32'd7, 32'hFFFF_FFFD, 0, "mulhu");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd3, 0, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, "rem");
    run_op(3'd5, 32'd100, 32'd7, 0, "divu");
    run_op(3'd7, 32'd100, 32'd7, 0, "remu");
    run_op(3'd5, 32'd5, 32'd0, 0, "divu_z");
    run_op(3'd6, 32'd5, 32'd0, 0, "rem_z");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    run_op(3'd4, 32'd100, 32'd7, 10, "backpressure");

    // Flush in cycle 5 of CALC
    s_before = S;
    Sel = 3'd5; A = 32'd1000; B = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_calc_ready", in_ready, 1);
    check("flush_calc_valid", out_valid, 0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("flush_calc_no_result", cnt, 0);
    check("flush_calc_S_held", S, s_before);

    // Flush beats acceptance in IDLE
    Sel = 3'd5; A = 32'd9; B = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_ready", in_ready, 1);
    @(negedge clk);
    check("flush_idle_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // Flush beats out_ready in DONE
    Sel = 3'd7; A = 32'd9; B = 32'd0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_done_pre", out_valid, 1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; out_ready = 1'b0;
    check("flush_done_valid", out_valid, 0);
    check("flush_done_ready", in_ready, 1);

    // Random operations
    for (int k = 0; k < 60; k++) begin
      rsel = 3'($urandom_range(0, 7));
      ra   = $urandom;
      rb   = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'hFFFF_FFFF - 32'($urandom_range(0, 100));
        4: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(rsel, ra, rb, $urandom_range(0, 2), $sformatf("rnd%0d_sel%0d", k, rsel));
    end

    // Reset in the middle of CALC
    Sel = 3'd3; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_S", S, 0);
    check("rst_mid_dz", div_zero, 0);
    @(negedge clk);
    reset = 1'b1;
    run_op(3'd5, 32'd100, 32'd7, 0, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: size, 32, operand and result width in bits; legal values are even and >= 4.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; asserting it clears all state immediately, and release is synchronised to clk by the integrator.
REQ-004 Port: in_valid  input  1  operation request.
REQ-005 Port: in_ready  output  1  unit can accept a request.
REQ-006 Port: A  input  size  operand 1 (multiplicand / dividend).
REQ-007 Port: B  input  size  operand 2 (multiplier / divisor).
REQ-008 Port: Sel  input  3  operation code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-009 Port: flush  input  1  abort the operation in flight.
REQ-010 Port: out_valid  output  1  result available.
REQ-011 Port: out_ready  input  1  consumer accepts the result.
REQ-012 Port: S  output  size  result.
REQ-013 Port: div_zero  output  1  the current result came from a division or remainder by zero; qualified by out_valid.

Function
REQ-014 The unit SHALL use three states: IDLE, CALC and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE.
- Handshake: a request is accepted when in_valid and in_ready are both 1 on a clock edge.
- On acceptance, A, B and Sel are captured; later changes to the inputs have no effect on that operation.
REQ-016 IDLE transitions on acceptance:
- Normal operation: go to CALC, with the iteration counter loaded with size.
- Special division case (REQ-021 or REQ-022): go straight to DONE.
REQ-017 CALC SHALL perform exactly one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide) and decrement the counter.
- When the counter reaches 0, the unit SHALL move to DONE.
- Latency from the acceptance edge to out_valid = 1 is size+1 cycles for a normal operation and 1 cycle for a special case.
REQ-018 DONE SHALL hold out_valid = 1, with S and div_zero stable, until out_ready = 1 on a clock edge, then return to IDLE.
- A new request cannot be accepted on that same edge; throughput is at most one operation per size+2 cycles.
REQ-019 Signedness:
- Signed operands: MULH (both), MULHSU (A only), DIV and REM (both).
- The unit SHALL operate on magnitudes and apply sign correction at completion.
REQ-020 Multiply results:
- MUL returns bits [size-1:0] of the 2*size-bit product.
- MULH, MULHSU and MULHU return bits [2*size-1:size].
REQ-021 Division by zero (B = 0):
- DIV and DIVU return all ones.
- REM and REMU return A.
- div_zero = 1.
REQ-022 Signed overflow (DIV or REM with A = 2^(size-1) and B = all ones):
- DIV returns A.
- REM returns 0.
- div_zero = 0.
REQ-023 Signed results:
- Quotient sign = sign(A) XOR sign(B).
- Remainder sign = sign(A).
- Division truncates toward zero.
REQ-024 flush = 1 on an edge SHALL force the unit to IDLE from any state and discard the result.
- Flush has priority over acceptance and over out_ready.
- in_ready is 0 on the flushing cycle only if the unit was not already in IDLE.
REQ-025 In IDLE and CALC, S and div_zero SHALL hold the previous result; they carry no meaning while out_valid = 0.

Reset
REQ-026 While reset = 0, the unit SHALL be in IDLE with in_ready = 1, out_valid = 0, S = 0, div_zero = 0, and the counter and all datapath registers cleared.
REQ-027 Asserting reset in the middle of an operation SHALL abandon it with no result delivered, and the first edge after release SHALL be able to accept a request.

Verification (size = 32)
REQ-028 MUL, A = 7, B = -3 (0xFFFFFFFD) -> out_valid 33 cycles after acceptance, S = 0xFFFFFFEB; MULH with the same operands -> S = 0xFFFFFFFF; MULHU -> S = 0x00000006.
REQ-029 DIV, A = -7, B = 2 -> S = 0xFFFFFFFD; REM with the same operands -> S = 0xFFFFFFFF; DIVU, A = 100, B = 7 -> S = 14; REMU with the same operands -> S = 2.
REQ-030 DIVU, A = 5, B = 0 -> out_valid 1 cycle after acceptance, S = 0xFFFFFFFF, div_zero = 1; REM, A = 5, B = 0 -> S = 5.
REQ-031 DIV, A = 0x80000000, B = 0xFFFFFFFF -> S = 0x80000000 after 1 cycle; REM with the same operands -> S = 0.
REQ-032 Back-pressure, flush and reset:
- Hold out_ready = 0 for 10 cycles in DONE -> S stable and in_ready = 0 throughout.
- Flush in cycle 5 of CALC -> IDLE on the next cycle and no out_valid.
- Reset asserted during CALC -> all outputs at reset values immediately.
